// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: width,
// operation codes, FSM encoding and operand-signedness helpers.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  // funct7 value that routes an R-type instruction to this block.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_PREP_ENC  = 3'd1;
  localparam logic [2:0] ST_ITER_ENC  = 3'd2;
  localparam logic [2:0] ST_FINAL_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_PREP  = ST_PREP_ENC,
    S_ITER  = ST_ITER_ENC,
    S_FINAL = ST_FINAL_ENC,
    S_DONE  = ST_DONE_ENC
  } state_e;

  // rs1 is a signed operand for MULH, MULHSU, DIV and REM.
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is a signed operand for MULH, DIV and REM.
  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step. The 2*XLEN accumulator holds {high, low}:
// multiply keeps {partial product, remaining multiplier bits},
// divide keeps {partial remainder, dividend/quotient bits}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // Shift-add for multiply, restoring trial subtract for divide.
  always_comb begin
    // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
    acc_next = acc;
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    fits     = shifted >= {1'b0, opnd};
    // When the divisor fits, the true difference is below 2^XLEN, so XLEN bits suffice.
    diff     = shifted[XLEN-1:0] - opnd;
    if (!is_div) begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end else if (fits) begin
      acc_next = {diff, acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: IDLE -> PREP -> ITER(XLEN)
// -> FINAL -> DONE, with a PREP->FINAL shortcut for divide-by-zero and
// signed overflow. Holds the pipeline through stall_o while working.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   opnd_q;     // rs2 at accept; multiplicand/divisor magnitude after PREP
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_step;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_lo_q;   // negate product / quotient
  logic              neg_rem_q;  // negate remainder (dividend was negative)
  logic [XLEN-1:0]   result_q;

  logic              is_div, sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign is_div   = op_q[2];
  assign sign_a   = rs1_is_signed(op_q) & rs1_q[XLEN-1];
  assign sign_b   = rs2_is_signed(op_q) & opnd_q[XLEN-1];
  // Negating INT_MIN wraps to itself, which is the correct unsigned magnitude.
  assign abs_a    = sign_a ? -rs1_q : rs1_q;
  assign abs_b    = sign_b ? -opnd_q : opnd_q;
  assign div_zero = is_div & (opnd_q == '0);
  assign div_ovf  = is_div & ~op_q[0] & (rs1_q == INT_MIN) & (opnd_q == '1);

  assign prod = neg_lo_q  ? -acc_q : acc_q;
  assign quo  = neg_lo_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  // Select the architectural result for the latched operation.
  always_comb begin
    final_res = '0;
    case (op_q)
      F3_MUL:                       final_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_i) state_nxt = S_PREP;
        S_PREP:  state_nxt = (div_zero || div_ovf) ? S_FINAL : S_ITER;
        S_ITER:  if (cnt_q == CNT_W'(XLEN-1)) state_nxt = S_FINAL;
        S_FINAL: state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, preparation, iteration and result register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: datapath registers are plain flops, not memory, so they are all cleared by reset.
    if (!reset) begin
      op_q      <= '0;
      rs1_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (!flush_i) begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op_q   <= funct3_i;
            rs1_q  <= rs1_data_i;
            opnd_q <= rs2_data_i;
          end
        end
        S_PREP: begin
          cnt_q <= '0;
          if (div_zero) begin
            acc_q     <= {rs1_q, {XLEN{1'b1}}};
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
          end else if (div_ovf) begin
            acc_q     <= {{XLEN{1'b0}}, INT_MIN};
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
          end else begin
            neg_lo_q  <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            if (is_div) begin
              acc_q  <= {{XLEN{1'b0}}, abs_a};
              opnd_q <= abs_b;
            end else begin
              acc_q  <= {{XLEN{1'b0}}, abs_b};
              opnd_q <= abs_a;
            end
          end
        end
        S_ITER: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_FINAL: result_q <= final_res;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state == S_PREP) || (state == S_ITER) || (state == S_FINAL);
  assign done_o   = (state == S_DONE);
  assign stall_o  = ((state == S_IDLE) && start_i) || busy_o;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Cycle 0 is the cycle in which
// start_i is presented in IDLE; inputs change and outputs are sampled
// on the falling edge.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] result_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  // Issue one operation from IDLE, scrub operands after cycle 0, and report
  // the cycle done_o rose (-1 if it never did) and the result then.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = f3;
    rs1_data_i = a;
    rs2_data_i = b;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i    = 1'b0;
        funct3_i   = 3'b000;
        rs1_data_i = '0;
        rs2_data_i = '0;
      end
      if (done_o === 1'b1) begin
        lat = c;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
    chk_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else pass_cnt++;
    chk_cnt++; if (result_o !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result_o); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_multiply();
    vec_t v[$];
    int lat;
    logic [31:0] res;
    v.push_back('{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 35, "mul_7_m3"});
    v.push_back('{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, "mulhu_max"});
    v.push_back('{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35, "mulh_min_min"});
    v.push_back('{F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 35, "mulhsu_m1_2"});
    v.push_back('{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 35, "mul_shift"});
    v.push_back('{F3_MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 35, "mulh_m3_5"});
    v.push_back('{F3_MULHU,  32'h80000000, 32'h00000004, 32'h00000002, 35, "mulhu_2p33"});
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].a, v[i].b, lat, res);
      chk_cnt++;
      if (lat !== v[i].lat) $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== v[i].exp) $display("FAIL %s_result: got %h expected %h", v[i].name, res, v[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_divide();
    vec_t v[$];
    int lat;
    logic [31:0] res;
    v.push_back('{F3_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 35, "div_m7_2"});
    v.push_back('{F3_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 35, "rem_m7_2"});
    v.push_back('{F3_DIVU, 32'd100,      32'd7,        32'd14,       35, "divu_100_7"});
    v.push_back('{F3_REMU, 32'd100,      32'd7,        32'd2,        35, "remu_100_7"});
    v.push_back('{F3_DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 35, "div_20_m3"});
    v.push_back('{F3_REM,  32'd20,       32'hFFFFFFFD, 32'h00000002, 35, "rem_20_m3"});
    v.push_back('{F3_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35, "divu_min_max"});
    v.push_back('{F3_DIVU, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 35, "divu_max_1"});
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].a, v[i].b, lat, res);
      chk_cnt++;
      if (lat !== v[i].lat) $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== v[i].exp) $display("FAIL %s_result: got %h expected %h", v[i].name, res, v[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_fast_path();
    vec_t v[$];
    int lat;
    logic [31:0] res;
    v.push_back('{F3_DIVU, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 3, "divu_by_zero"});
    v.push_back('{F3_REM,  32'h00001234, 32'h00000000, 32'h00001234, 3, "rem_by_zero"});
    v.push_back('{F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3, "div_overflow"});
    v.push_back('{F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3, "rem_overflow"});
    v.push_back('{F3_REMU, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 3, "remu_by_zero"});
    v.push_back('{F3_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 3, "div_neg_by_zero"});
    foreach (v[i]) begin
      do_op(v[i].f3, v[i].a, v[i].b, lat, res);
      chk_cnt++;
      if (lat !== v[i].lat) $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== v[i].exp) $display("FAIL %s_result: got %h expected %h", v[i].name, res, v[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = F3_MUL;
    rs1_data_i = 32'd3;
    rs2_data_i = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy_o); else pass_cnt++;
    reset = 1'b0;
    #1;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy_o); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL mid_reset_stall: got %b expected 0", stall_o); else pass_cnt++;
    chk_cnt++; if (result_o !== 32'h0) $display("FAIL mid_reset_result: got %h expected 00000000", result_o); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0) done_seen++;
    end
    chk_cnt++; if (done_seen !== 0) $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_seen); else pass_cnt++;
    chk_cnt++; if (result_o !== 32'h0) $display("FAIL mid_reset_result_after: got %h expected 00000000", result_o); else pass_cnt++;
  endtask

  // start_i held high through one full op, a second op accepted right after
  // DONE, then flushed in its cycle 20; finally flush and start together in IDLE.
  task automatic test_back_to_back();
    int stall_errs = 0;
    int done_cyc   = -1;
    int late_done  = 0;
    @(negedge clk);
    start_i    = 1'b1;
    funct3_i   = F3_MULHU;
    rs1_data_i = 32'h00010000;
    rs2_data_i = 32'h00010000;
    #1;
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) @(negedge clk);
      if (c <= 34 && stall_o !== 1'b1) stall_errs++;
      if (c <= 35 && done_o === 1'b1 && done_cyc < 0) done_cyc = c;
      if (c == 35) begin
        chk_cnt++; if (stall_o !== 1'b0) $display("FAIL hs_stall_done: got %b expected 0", stall_o); else pass_cnt++;
        chk_cnt++; if (result_o !== 32'h1) $display("FAIL hs_result: got %h expected 00000001", result_o); else pass_cnt++;
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd1;
        funct3_i   = F3_DIVU;
      end
      if (c == 36) begin
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL hs_idle_busy: got %b expected 0", busy_o); else pass_cnt++;
        chk_cnt++; if (stall_o !== 1'b1) $display("FAIL hs_idle_stall: got %b expected 1", stall_o); else pass_cnt++;
      end
      if (c == 37) begin
        chk_cnt++; if (busy_o !== 1'b1) $display("FAIL hs_second_accept: got %b expected 1", busy_o); else pass_cnt++;
        start_i = 1'b0;
      end
      if (c == 56) flush_i = 1'b1;
      if (c == 57) begin
        flush_i = 1'b0;
        #1;
        chk_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy_o); else pass_cnt++;
        chk_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_o); else pass_cnt++;
      end
      if (c > 36 && done_o !== 1'b0) late_done++;
    end
    chk_cnt++; if (stall_errs !== 0) $display("FAIL hs_stall_window: got %0d low cycles expected 0", stall_errs); else pass_cnt++;
    chk_cnt++; if (done_cyc !== 35) $display("FAIL hs_done_cycle: got %0d expected 35", done_cyc); else pass_cnt++;
    chk_cnt++; if (late_done !== 0) $display("FAIL flush_no_done: got %0d pulses expected 0", late_done); else pass_cnt++;
    chk_cnt++; if (result_o !== 32'h1) $display("FAIL flush_result_kept: got %h expected 00000001", result_o); else pass_cnt++;

    @(negedge clk);
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = F3_DIVU;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL flush_beats_start: got %b expected 0", busy_o); else pass_cnt++;
    late_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0) late_done++;
    end
    chk_cnt++; if (late_done !== 0) $display("FAIL flush_start_no_done: got %0d pulses expected 0", late_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_reset_mid();
    test_divide();
    test_fast_path();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
